axi4lite_mem_slave: RTL and testbench

//  Parametrised AXI4-Lite slave with a word-organised on-chip RAM.

---
 rtl/axi4lite_mem_slave.sv | 195 +++++++++++++++++++
 tb/tb_axi4lite_mem_slave.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_mem_slave.sv
// AXI4-Lite slave backed by a word-organised RAM with byte-lane writes.
// Optional macro AXIL_PROT_CHECK_EN: reject unprivileged writes (AWPROT[0]=0).
module axi4lite_mem_slave #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 1024
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic [ADDR_W+2:0]        AW,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [DATA_W+DATA_W/8-1:0] W,
    input  logic                     WVALID,
    output logic                     WREADY,
    output logic [1:0]               B,
    output logic                     BVALID,
    input  logic                     BREADY,
    input  logic [ADDR_W+2:0]        AR,
    input  logic                     ARVALID,
    output logic                     ARREADY,
    output logic [DATA_W+1:0]        R,
    output logic                     RVALID,
    input  logic                     RREADY
);

    localparam int NB  = DATA_W / 8;
    localparam int LSB = $clog2(NB);
    localparam int IW  = ADDR_W - LSB;
    localparam int MW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW:0] LIMIT = (IW+1)'(DEPTH);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_AHELD, W_DHELD, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_RESP} rstate_t;

    wstate_t r_wst, w_wst_nxt;
    rstate_t r_rst, w_rst_nxt;

    logic [ADDR_W-1:0] r_awaddr;
    logic [2:0]        r_awprot;
    logic [DATA_W-1:0] r_wdata;
    logic [NB-1:0]     r_wstrb;
    logic [1:0]        r_bresp;
    logic [DATA_W+1:0] r_r;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_commit;
    logic              w_ar_hs;
    logic [ADDR_W-1:0] w_caddr;
    logic [2:0]        w_cprot;
    logic [DATA_W-1:0] w_cdata;
    logic [NB-1:0]     w_cstrb;
    logic [IW-1:0]     w_cidx;
    logic              w_cinr;
    logic              w_cok;
    logic              w_we;
    logic [IW-1:0]     w_ridx;
    logic              w_rinr;
    logic              w_unused;

    // Commit operands: whichever half arrived earlier comes from its latch
    assign w_caddr = (r_wst == W_AHELD) ? r_awaddr : AW[ADDR_W-1:0];
    assign w_cprot = (r_wst == W_AHELD) ? r_awprot : AW[ADDR_W+2:ADDR_W];
    assign w_cdata = (r_wst == W_DHELD) ? r_wdata : W[DATA_W-1:0];
    assign w_cstrb = (r_wst == W_DHELD) ? r_wstrb : W[DATA_W+NB-1:DATA_W];
    assign w_cidx  = w_caddr[ADDR_W-1:LSB];
    assign w_cinr  = {1'b0, w_cidx} < LIMIT;
`ifdef AXIL_PROT_CHECK_EN
    assign w_cok   = w_cinr && w_cprot[0];
`else
    assign w_cok   = w_cinr;
`endif
    assign w_we    = w_commit && w_cok;

    assign w_ridx  = AR[ADDR_W-1:LSB];
    assign w_rinr  = {1'b0, w_ridx} < LIMIT;

    assign BVALID  = (r_wst == W_RESP);
    assign B       = r_bresp;
    assign RVALID  = (r_rst == R_RESP);
    assign R       = r_r;

    assign w_unused = ^{w_cprot, w_caddr[LSB-1:0],
                        AR[ADDR_W+2:ADDR_W], AR[LSB-1:0]};

    // Write FSM next state, channel readies and commit strobe
    always_comb begin
        w_wst_nxt = r_wst;
        AWREADY   = 1'b0;
        WREADY    = 1'b0;
        w_commit  = 1'b0;
        unique case (r_wst)
            W_IDLE: begin
                AWREADY = 1'b1;
                WREADY  = 1'b1;
                if (AWVALID && WVALID) begin
                    w_commit  = 1'b1;
                    w_wst_nxt = W_RESP;
                end else if (AWVALID) begin
                    w_wst_nxt = W_AHELD;
                end else if (WVALID) begin
                    w_wst_nxt = W_DHELD;
                end
            end
            W_AHELD: begin
                WREADY = 1'b1;
                if (WVALID) begin
                    w_commit  = 1'b1;
                    w_wst_nxt = W_RESP;
                end
            end
            W_DHELD: begin
                AWREADY = 1'b1;
                if (AWVALID) begin
                    w_commit  = 1'b1;
                    w_wst_nxt = W_RESP;
                end
            end
            W_RESP: begin
                if (BREADY) w_wst_nxt = W_IDLE;
            end
            default: w_wst_nxt = W_IDLE;
        endcase
    end

    // Write state, half-transaction latches and registered response
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wst    <= W_IDLE;
            r_awaddr <= '0;
            r_awprot <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_bresp  <= OKAY;
        end else begin
            r_wst <= w_wst_nxt;
            if (AWVALID && AWREADY) begin
                r_awaddr <= AW[ADDR_W-1:0];
                r_awprot <= AW[ADDR_W+2:ADDR_W];
            end
            if (WVALID && WREADY) begin
                r_wdata <= W[DATA_W-1:0];
                r_wstrb <= W[DATA_W+NB-1:DATA_W];
            end
            if (w_commit) r_bresp <= w_cok ? OKAY : SLVERR;
        end
    end

    // RAM byte-lane write; contents survive reset
    always_ff @(posedge ACLK) begin
        if (w_we) begin
            for (int i = 0; i < NB; i++) begin
                if (w_cstrb[i])
                    r_mem[w_cidx[MW-1:0]][i*8 +: 8] <= w_cdata[i*8 +: 8];
            end
        end
    end

    // Read FSM next state and address acceptance
    always_comb begin
        w_rst_nxt = r_rst;
        ARREADY   = 1'b0;
        w_ar_hs   = 1'b0;
        unique case (r_rst)
            R_IDLE: begin
                ARREADY = 1'b1;
                if (ARVALID) begin
                    w_ar_hs   = 1'b1;
                    w_rst_nxt = R_RESP;
                end
            end
            R_RESP: begin
                if (RREADY) w_rst_nxt = R_IDLE;
            end
            default: w_rst_nxt = R_IDLE;
        endcase
    end

    // Read state and registered R; RAM read sees pre-write contents
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rst <= R_IDLE;
            r_r   <= '0;
        end else begin
            r_rst <= w_rst_nxt;
            if (w_ar_hs) begin
                if (w_rinr) r_r <= {OKAY, r_mem[w_ridx[MW-1:0]]};
                else        r_r <= {SLVERR, {DATA_W{1'b0}}};
            end
        end
    end

endmodule

// File: tb/tb_axi4lite_mem_slave.sv
// Scoreboard bench for axi4lite_mem_slave (32-bit, 13-bit address, 1024 words).
// Directed scenarios followed by randomized traffic against a word-array model.
module tb_axi4lite_mem_slave;

    localparam int DEPTH = 1024;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [15:0] AW = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [35:0] W = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  B;
    logic        BVALID;
    logic        BREADY = 1'b1;
    logic [15:0] AR = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [33:0] R;
    logic        RVALID;
    logic        RREADY = 1'b1;

    int checks = 0;
    int failures = 0;
    int bmode = 0;
    int rmode = 0;

    logic [1:0]  bq[$];
    logic [33:0] rq[$];
    logic [31:0] mm [32];

    axi4lite_mem_slave #(.DATA_W(32), .ADDR_W(13), .DEPTH(DEPTH)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AW(AW), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .W(W), .WVALID(WVALID), .WREADY(WREADY),
        .B(B), .BVALID(BVALID), .BREADY(BREADY),
        .AR(AR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .R(R), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Response-ready drivers: 0 = always ready, 1 = random, 2 = stalled
    initial begin
        forever begin
            @(posedge ACLK);
            #1;
            BREADY = (bmode == 0) ? 1'b1 :
                     (bmode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
            RREADY = (rmode == 0) ? 1'b1 :
                     (rmode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
        end
    end

    // Monitor: pop and compare on every B/R handshake
    always @(negedge ACLK) begin
        if (ARESETN) begin
            if (BVALID && BREADY) begin
                if (bq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL b_unexpected: got %b expected none", B);
                end else begin
                    chk("bresp", {62'd0, B}, {62'd0, bq.pop_front()});
                end
            end
            if (RVALID && RREADY) begin
                if (rq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL r_unexpected: got %h expected none", R);
                end else begin
                    chk("rdata", {30'd0, R}, {30'd0, rq.pop_front()});
                end
            end
        end
    end

    // Reference model: word array, SLVERR beyond DEPTH
    function automatic bit in_rng(input logic [12:0] a);
        return int'(a[12:2]) < DEPTH;
    endfunction

    function automatic bit wr_ok(input logic [12:0] a, input logic [2:0] p);
`ifdef AXIL_PROT_CHECK_EN
        return in_rng(a) && p[0];
`else
        return in_rng(a) && (p == p);
`endif
    endfunction

    task automatic wr_expect(input logic [12:0] a, input logic [2:0] p,
                             input logic [31:0] d, input logic [3:0] s);
        int idx;
        idx = int'(a[12:2]);
        if (wr_ok(a, p)) begin
            bq.push_back(2'b00);
            for (int i = 0; i < 4; i++)
                if (s[i]) mm[idx][i*8 +: 8] = d[i*8 +: 8];
        end else begin
            bq.push_back(2'b10);
        end
    endtask

    task automatic rd_expect(input logic [12:0] a);
        if (in_rng(a)) rq.push_back({2'b00, mm[int'(a[12:2])]});
        else           rq.push_back({2'b10, 32'h0});
    endtask

    function automatic logic rdy(input int which);
        case (which)
            0:       return AWREADY && WREADY;
            1:       return AWREADY;
            2:       return WREADY;
            default: return ARREADY;
        endcase
    endfunction

    // Wait for the selected ready, then step past the handshake edge
    task automatic hs(input int which, input string nm);
        int n;
        n = 0;
        forever begin
            @(negedge ACLK);
            if (rdy(which)) break;
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $display("FAIL %s_timeout: got no ready expected ready", nm);
                break;
            end
        end
        @(posedge ACLK);
        #1;
    endtask

    // mode 0: AW+W together; 1: AW then W; 2: W then AW
    task automatic wr_drive(input logic [12:0] a, input logic [2:0] p,
                            input logic [31:0] d, input logic [3:0] s,
                            input int mode, input int gap);
        AW = {p, a};
        W  = {s, d};
        if (mode == 0) begin
            AWVALID = 1'b1;
            WVALID  = 1'b1;
            hs(0, "aw_w");
            AWVALID = 1'b0;
            WVALID  = 1'b0;
        end else if (mode == 1) begin
            AWVALID = 1'b1;
            hs(1, "aw");
            AWVALID = 1'b0;
            repeat (gap) @(posedge ACLK);
            #1;
            WVALID = 1'b1;
            hs(2, "w");
            WVALID = 1'b0;
        end else begin
            WVALID = 1'b1;
            hs(2, "w");
            WVALID = 1'b0;
            repeat (gap) @(posedge ACLK);
            #1;
            AWVALID = 1'b1;
            hs(1, "aw");
            AWVALID = 1'b0;
        end
    endtask

    task automatic do_write(input logic [12:0] a, input logic [2:0] p,
                            input logic [31:0] d, input logic [3:0] s,
                            input int mode, input int gap);
        wr_expect(a, p, d, s);
        wr_drive(a, p, d, s, mode, gap);
    endtask

    task automatic rd_drive(input logic [12:0] a, input logic [2:0] p);
        AR = {p, a};
        ARVALID = 1'b1;
        hs(3, "ar");
        ARVALID = 1'b0;
    endtask

    task automatic do_read(input logic [12:0] a);
        rd_expect(a);
        rd_drive(a, 3'($urandom_range(0, 7)));
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((bq.size() != 0 || rq.size() != 0 || BVALID || RVALID)
               && n < 1000) begin
            @(posedge ACLK);
            n++;
        end
        #1;
        chk(nm, 64'(bq.size() + rq.size()), 64'd0);
    endtask

    function automatic logic [12:0] rand_addr();
        int idx;
        if ($urandom_range(0, 9) < 8) idx = $urandom_range(0, 31);
        else                          idx = 1024 + $urandom_range(0, 7);
        return 13'(idx * 4 + $urandom_range(0, 3));
    endfunction

    initial begin
        #12;
        chk("rst_awready", AWREADY, 1);
        chk("rst_wready", WREADY, 1);
        chk("rst_arready", ARREADY, 1);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_b", B, 0);
        chk("rst_r", R, 0);
        #6 ARESETN = 1'b1;
        repeat (2) @(posedge ACLK);
        #1;

        for (int i = 0; i < 32; i++)
            do_write(13'(i * 4), 3'b001, $urandom, 4'hF, 0, 0);

        // AW first, W three cycles later; B one cycle after W handshake
        wr_expect(13'h010, 3'b001, 32'hDEADBEEF, 4'hF);
        AW = {3'b001, 13'h010};
        W  = {4'hF, 32'hDEADBEEF};
        AWVALID = 1'b1;
        hs(1, "aw");
        AWVALID = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        chk("t2_bvalid_pre", BVALID, 0);
        WVALID = 1'b1;
        hs(2, "w");
        WVALID = 1'b0;
        chk("t2_bvalid_lat", BVALID, 1);
        chk("t2_b", B, 2'b00);
        rq.push_back({2'b00, 32'hDEADBEEF});
        rd_drive(13'h010, 3'b000);

        // Partial strobe to an unaligned byte address
        do_write(13'h013, 3'b001, 32'h11223344, 4'h5, 0, 0);
        rq.push_back({2'b00, 32'hDE22BE44});
        rd_drive(13'h010, 3'b000);

        // Out of range write and read; index 1 must stay untouched
        do_write(13'h1004, 3'b001, 32'h55AA55AA, 4'hF, 2, 1);
        rq.push_back({2'b10, 32'h0});
        rd_drive(13'h1004, 3'b000);
        do_read(13'h004);

        // Unprivileged write
        do_write(13'h020, 3'b000, 32'hCAFEF00D, 4'hF, 0, 0);
`ifdef AXIL_PROT_CHECK_EN
        do_read(13'h020);
`else
        rq.push_back({2'b00, 32'hCAFEF00D});
        rd_drive(13'h020, 3'b000);
`endif

        // Zero strobe leaves the word alone
        do_write(13'h018, 3'b001, 32'hFFFFFFFF, 4'h0, 1, 0);
        do_read(13'h018);

        // Read and write commit on the same edge: read sees old word
        drain("drain_rbw");
        rd_expect(13'h014);
        wr_expect(13'h014, 3'b001, 32'h0BADF00D, 4'hF);
        fork
            wr_drive(13'h014, 3'b001, 32'h0BADF00D, 4'hF, 0, 0);
            rd_drive(13'h014, 3'b000);
        join
        do_read(13'h014);

        // B back-pressure
        drain("drain_bstall");
        bmode = 2;
        @(posedge ACLK);
        #1;
        do_write(13'h030, 3'b001, 32'h13579BDF, 4'hF, 0, 0);
        wr_expect(13'h034, 3'b001, 32'h2468ACE0, 4'hF);
        fork
            wr_drive(13'h034, 3'b001, 32'h2468ACE0, 4'hF, 0, 0);
            begin
                repeat (5) begin
                    @(negedge ACLK);
                    chk("bstall_bvalid", BVALID, 1);
                    chk("bstall_b", B, 2'b00);
                    chk("bstall_awready", AWREADY, 0);
                    chk("bstall_wready", WREADY, 0);
                end
                bmode = 0;
            end
        join

        // R back-pressure
        drain("drain_rstall");
        rmode = 2;
        @(posedge ACLK);
        #1;
        rq.push_back({2'b00, 32'h13579BDF});
        rd_drive(13'h030, 3'b000);
        repeat (5) begin
            @(negedge ACLK);
            chk("rstall_rvalid", RVALID, 1);
            chk("rstall_r", {30'd0, R}, {30'd0, 2'b00, 32'h13579BDF});
            chk("rstall_arready", ARREADY, 0);
        end
        rmode = 0;

        // Reset during a half-done write drops it
        drain("drain_reset");
        AW = {3'b001, 13'h040};
        W  = {4'hF, ~mm[16]};
        AWVALID = 1'b1;
        hs(1, "aw");
        AWVALID = 1'b0;
        WVALID = 1'b1;
        ARESETN = 1'b0;
        #2;
        chk("rst2_awready", AWREADY, 1);
        chk("rst2_wready", WREADY, 1);
        chk("rst2_arready", ARREADY, 1);
        chk("rst2_bvalid", BVALID, 0);
        chk("rst2_rvalid", RVALID, 0);
        chk("rst2_r", R, 0);
        WVALID = 1'b0;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(posedge ACLK);
        #1;
        do_read(13'h040);

        // Randomized traffic with random response back-pressure
        bmode = 1;
        rmode = 1;
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 1) == 0)
                do_write(rand_addr(), 3'($urandom_range(0, 7)), $urandom,
                         4'($urandom_range(0, 15)), $urandom_range(0, 2),
                         $urandom_range(0, 3));
            else
                do_read(rand_addr());
        end
        bmode = 0;
        rmode = 0;
        drain("drain_final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
